// File: rtl/feed_sched_pkg.sv
// ---------------------------------------------------------------------------
// systola_pkg
// Shared definitions for the systolic feed scheduler slice.
//   state_t             - scheduler state encoding (IDLE, FEED, DRAIN, DONE)
//   DEF_ROWS/COLS/KW    - default array geometry and k_len operand width
// ---------------------------------------------------------------------------
package systola_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEF_ROWS = 4;
  localparam int DEF_COLS = 4;
  localparam int DEF_KW   = 6;

endpackage

// File: rtl/feed_sched_if.sv
// ---------------------------------------------------------------------------
// feed_sched_if
// Bundles the control handshake and per-row buffer signals of feed_sched.
//   start, k_len  - tile pass request and its row length (host -> scheduler)
//   buf_empty     - per-row empty flags (buffers -> scheduler)
//   buf_rd        - per-row read strobes (scheduler -> buffers)
//   pe_en         - PE array advance enable
//   acc_clr       - one-cycle accumulator clear
//   busy, done    - status and completion pulse
// Modports: master = host/testbench side, slave = scheduler side.
// ---------------------------------------------------------------------------
interface feed_sched_if #(
  parameter int ROWS = 4,
  parameter int KW   = 6
);

  logic            start;
  logic [KW-1:0]   k_len;
  logic [ROWS-1:0] buf_empty;
  logic [ROWS-1:0] buf_rd;
  logic            pe_en;
  logic            acc_clr;
  logic            busy;
  logic            done;

  modport master (
    output start, k_len, buf_empty,
    input  buf_rd, pe_en, acc_clr, busy, done
  );

  modport slave (
    input  start, k_len, buf_empty,
    output buf_rd, pe_en, acc_clr, busy, done
  );

endinterface

// File: rtl/feed_sched.sv
// ---------------------------------------------------------------------------
// feed_sched
// Feeds a ROWS x COLS systolic PE array from per-row input buffers. Each row
// is read for K consecutive steps, skewed by one step per row, so a pass has
// K+ROWS-1 feed steps, then COLS drain cycles, then a one-cycle done pulse.
// A feed step stalls (no reads, no PE advance) whenever a row that needs a
// word has an empty buffer.
// Ports:
//   clk   - clock, rising edge
//   rstn  - synchronous active-low reset
//   bus   - feed_sched_if.slave (start/k_len in, buf_empty in, buf_rd,
//           pe_en, acc_clr, busy, done out)
// ---------------------------------------------------------------------------
module feed_sched
  import systola_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int KW   = DEF_KW
) (
  input logic         clk,
  input logic         rstn,
  feed_sched_if.slave bus
);

  // Step counter is wide enough for the last step K+ROWS-2 with K at its max.
  localparam int TW = KW + $clog2(ROWS) + 1;
  localparam int DW = $clog2(COLS + 1);

  state_t          state;
  logic [KW-1:0]   k_reg;
  logic [TW-1:0]   t;
  logic [DW-1:0]   d;

  logic [TW-1:0]   k_ext;
  logic [TW-1:0]   last_t;
  logic [ROWS-1:0] want;
  logic [ROWS-1:0] blocked;
  logic            stall;
  logic            feed_go;

  assign k_ext  = TW'(k_reg);
  assign last_t = k_ext + TW'(ROWS - 2);

  // Row r needs a word while r <= t < r+K; a needed row with an empty buffer
  // blocks the whole step so the skew between rows is never broken.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    localparam logic [TW-1:0] ROW_IDX = TW'(r);
    assign want[r]    = (state == ST_FEED) && (t >= ROW_IDX) && (t < ROW_IDX + k_ext);
    assign blocked[r] = want[r] & bus.buf_empty[r];
  end

  assign stall   = |blocked;
  assign feed_go = (state == ST_FEED) && !stall;

  // Outputs decode from the registered state; all are forced low while rstn
  // is asserted so nothing leaks out during the reset cycle.
  assign bus.buf_rd  = (rstn && feed_go) ? want : '0;
  assign bus.pe_en   = rstn && (feed_go || (state == ST_DRAIN));
  assign bus.acc_clr = rstn && (state == ST_IDLE) && bus.start && (bus.k_len != '0);
  assign bus.busy    = rstn && (state != ST_IDLE);
  assign bus.done    = rstn && (state == ST_DONE);

  // Pass sequencing: start is only looked at in IDLE, a zero-length pass
  // jumps straight to DONE, feed steps advance only on non-stalled cycles.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= ST_IDLE;
      k_reg <= '0;
      t     <= '0;
      d     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            if (bus.k_len != '0) begin
              k_reg <= bus.k_len;
              t     <= '0;
              d     <= '0;
              state <= ST_FEED;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_FEED: begin
          if (!stall) begin
            t <= t + TW'(1);
            if (t == last_t) begin
              d     <= '0;
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (d == DW'(COLS - 1)) begin
            state <= ST_DONE;
          end else begin
            d <= d + DW'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_feed_sched.sv
// ---------------------------------------------------------------------------
// tb_feed_sched
// Self-checking bench for feed_sched (ROWS=4, COLS=4, KW=6). A cycle-level
// reference model built from the pass rules (skewed row windows, stall on
// any needed-but-empty row, K+ROWS-1 feed steps, COLS drain cycles, one done
// cycle) predicts every output each cycle; directed passes check completion
// timing, followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_feed_sched;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int KW   = 6;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  feed_sched_if #(.ROWS(ROWS), .KW(KW)) bus ();

  feed_sched #(.ROWS(ROWS), .COLS(COLS), .KW(KW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 feeding, 2 draining, 3 done cycle.
  // m_s = feed steps completed, m_drain = drain cycles still to go.
  int  m_phase = 0;
  int  m_k     = 0;
  int  m_s     = 0;
  int  m_drain = 0;
  int  rd_cnt[ROWS];
  bit  saw_done;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check outputs
  // 1 ns later, then advance the model to what the next cycle should be.
  task automatic apply_stimulus(input bit st, input logic [KW-1:0] k,
                                input logic [ROWS-1:0] emp, input bit rn);
    logic [ROWS-1:0] want;
    logic [ROWS-1:0] e_rd;
    bit e_pe, e_clr, e_busy, e_done, stall;
    @(negedge clk);
    rstn          = rn;
    bus.start     = st;
    bus.k_len     = k;
    bus.buf_empty = emp;
    #1;
    want = '0; e_rd = '0; e_pe = 0; e_clr = 0; e_busy = 0; e_done = 0; stall = 0;
    if (rn) begin
      case (m_phase)
        0: e_clr = st && (k != 0);
        1: begin
          e_busy = 1;
          for (int r = 0; r < ROWS; r++) want[r] = (r <= m_s) && (m_s < r + m_k);
          stall = |(want & emp);
          e_rd  = stall ? '0 : want;
          e_pe  = !stall;
        end
        2: begin e_busy = 1; e_pe = 1; end
        default: begin e_busy = 1; e_done = 1; end
      endcase
    end
    check_output("buf_rd",  32'(bus.buf_rd),  32'(e_rd));
    check_output("pe_en",   32'(bus.pe_en),   32'(e_pe));
    check_output("acc_clr", 32'(bus.acc_clr), 32'(e_clr));
    check_output("busy",    32'(bus.busy),    32'(e_busy));
    check_output("done",    32'(bus.done),    32'(e_done));
    for (int r = 0; r < ROWS; r++) if (bus.buf_rd[r] === 1'b1) rd_cnt[r]++;
    saw_done = (bus.done === 1'b1);
    if (rn && m_phase == 3)
      for (int r = 0; r < ROWS; r++) check_output("reads_per_row", 32'(rd_cnt[r]), 32'(m_k));
    if (!rn) begin
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (st) begin
          m_k = int'(k);
          m_s = 0;
          for (int r = 0; r < ROWS; r++) rd_cnt[r] = 0;
          m_phase = (k != 0) ? 1 : 3;
        end
        1: if (!stall) begin
          m_s++;
          if (m_s == m_k + ROWS - 1) begin m_phase = 2; m_drain = COLS; end
        end
        2: begin
          m_drain--;
          if (m_drain == 0) m_phase = 3;
        end
        default: m_phase = 0;
      endcase
    end
    cyc++;
  endtask

  // Start a pass at relative cycle 0, optionally hold row srow empty during
  // cycles s_from..s_to and poke start every third cycle; reports the
  // relative cycle of done, or -1 if it never came within limit cycles.
  task automatic run_pass(input int k, input int srow, input int s_from, input int s_to,
                          input bit poke, input int limit, output int done_at);
    logic [ROWS-1:0] emp;
    done_at = -1;
    apply_stimulus(1'b1, KW'(k), '0, 1'b1);
    for (int c = 1; c <= limit; c++) begin
      emp = (c >= s_from && c <= s_to) ? ROWS'(1 << srow) : '0;
      apply_stimulus(poke && (c % 3 == 2), KW'(k), emp, 1'b1);
      if (saw_done) begin
        done_at = c;
        break;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, '0, '0, 1'b1);
  endtask

  int done_at;

  initial begin
    bus.start     = 1'b0;
    bus.k_len     = '0;
    bus.buf_empty = '0;
    for (int r = 0; r < ROWS; r++) rd_cnt[r] = 0;

    $display("[TB] reset");
    apply_stimulus(1'b1, 6'd3, '0, 1'b0);
    apply_stimulus(1'b0, '0, '0, 1'b0);
    idle_cycles(2);

    $display("[TB] basic pass K=3");
    run_pass(3, 0, 1, 0, 1'b0, 40, done_at);
    check_output("done_cycle_k3", 32'(done_at), 32'd11);
    idle_cycles(2);

    $display("[TB] row 2 empty during cycles 3-4");
    run_pass(3, 2, 3, 4, 1'b0, 40, done_at);
    check_output("done_cycle_stall", 32'(done_at), 32'd13);
    idle_cycles(2);

    $display("[TB] row 1 empty for the whole pass");
    run_pass(3, 1, 1, 25, 1'b0, 25, done_at);
    check_output("no_done_while_stalled", 32'(done_at), 32'hFFFF_FFFF);
    done_at = -1;
    for (int c = 1; c <= 20; c++) begin
      apply_stimulus(1'b0, 6'd3, '0, 1'b1);
      if (saw_done) begin done_at = c; break; end
    end
    check_output("done_after_release", 32'(done_at), 32'd10);
    idle_cycles(2);

    $display("[TB] zero-length pass");
    run_pass(0, 0, 1, 0, 1'b0, 5, done_at);
    check_output("done_cycle_k0", 32'(done_at), 32'd1);
    idle_cycles(2);

    $display("[TB] reset in the middle of a pass");
    apply_stimulus(1'b1, 6'd3, '0, 1'b1);
    for (int c = 1; c <= 4; c++) apply_stimulus(1'b0, 6'd3, '0, 1'b1);
    apply_stimulus(1'b0, 6'd3, '0, 1'b0);
    idle_cycles(1);
    run_pass(2, 0, 1, 0, 1'b0, 30, done_at);
    check_output("done_cycle_k2_after_reset", 32'(done_at), 32'd10);
    idle_cycles(2);

    $display("[TB] start pulses while busy");
    run_pass(3, 0, 1, 0, 1'b1, 40, done_at);
    check_output("done_cycle_poked", 32'(done_at), 32'd11);
    idle_cycles(3);

    $display("[TB] maximum K");
    run_pass(63, 0, 1, 0, 1'b0, 100, done_at);
    check_output("done_cycle_kmax", 32'(done_at), 32'd71);
    idle_cycles(2);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      logic [ROWS-1:0] emp;
      for (int r = 0; r < ROWS; r++) emp[r] = ($urandom_range(0, 4) == 0);
      apply_stimulus($urandom_range(0, 5) == 0,
                     KW'($urandom_range(0, 7)),
                     emp,
                     $urandom_range(0, 149) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
